// File: rtl/ram_pair_read_sequencer.sv
// rtl/ram_pair_read_sequencer.sv - walks two RAM read address streams and streams operand pairs through a 2-entry skid FIFO
module ram_pair_read_sequencer #(
    parameter int DATA_WIDTH = 1024,
    parameter int DEPTH      = 256,
    parameter int LEN_W      = 9,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base0,
    input  logic [ADDR_W-1:0]     base1,
    input  logic [LEN_W-1:0]      len,
    output logic [ADDR_W-1:0]     read_addr0,
    output logic [ADDR_W-1:0]     read_addr1,
    input  logic [DATA_WIDTH-1:0] ram_dout0,
    input  logic [DATA_WIDTH-1:0] ram_dout1,
    output logic [DATA_WIDTH-1:0] out_data0,
    output logic [DATA_WIDTH-1:0] out_data1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_issued;
    logic [ADDR_W-1:0]     r_addr0;
    logic [ADDR_W-1:0]     r_addr1;
    logic                  r_inflight;
    logic                  r_inflight_last;

    logic [DATA_WIDTH-1:0] r_fifo_d0 [2];
    logic [DATA_WIDTH-1:0] r_fifo_d1 [2];
    logic [1:0]            r_fifo_last;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_accept;
    logic [2:0]            w_occ;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(DEPTH - 1)) begin
            return '0;
        end
        return a + ADDR_W'(1);
    endfunction

    // occ counts the FIFO slots already spoken for, so a pop frees a slot for an issue in the same cycle
    assign w_pop    = (r_count != 2'd0) && out_ready;
    assign w_push   = r_inflight;
    assign w_occ    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue  = (r_state == S_RUN) && (r_issued < r_len) && (w_occ < 3'd2);
    assign w_accept = (r_state == S_IDLE) && start && (len != '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_issued == r_len) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_inflight && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_len           <= '0;
            r_issued        <= '0;
            r_addr0         <= '0;
            r_addr1         <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_issued == r_len - LEN_W'(1));
            if (w_accept) begin
                r_len    <= len;
                r_issued <= '0;
                r_addr0  <= base0;
                r_addr1  <= base1;
            end else if (w_issue) begin
                r_issued <= r_issued + LEN_W'(1);
                r_addr0  <= addr_inc(r_addr0);
                r_addr1  <= addr_inc(r_addr1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_fifo_last <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_fifo_d0[i] <= '0;
                r_fifo_d1[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_d0[r_wr_ptr]   <= ram_dout0;
                r_fifo_d1[r_wr_ptr]   <= ram_dout1;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(w_push && !w_pop && (r_count == 2'd2)));

    assign read_addr0 = r_addr0;
    assign read_addr1 = r_addr1;
    assign out_data0  = r_fifo_d0[r_rd_ptr];
    assign out_data1  = r_fifo_d1[r_rd_ptr];
    assign out_valid  = (r_count != 2'd0);
    assign out_last   = out_valid && r_fifo_last[r_rd_ptr];
    assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_ram_pair_read_sequencer.sv
// tb/tb_ram_pair_read_sequencer.sv - self-checking bench for ram_pair_read_sequencer
module tb_ram_pair_read_sequencer;

    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int LEN_W = 9;
    localparam int AW    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             out_ready;
    logic [AW-1:0]    base0;
    logic [AW-1:0]    base1;
    logic [LEN_W-1:0] len;
    logic [AW-1:0]    read_addr0;
    logic [AW-1:0]    read_addr1;
    logic [DW-1:0]    ram_dout0 = '0;
    logic [DW-1:0]    ram_dout1 = '0;
    logic [DW-1:0]    out_data0;
    logic [DW-1:0]    out_data1;
    logic             out_valid;
    logic             out_last;
    logic             busy;
    logic             done;

    logic [DW-1:0]    mem [DEPTH];

    int checks   = 0;
    int errors   = 0;
    int hs_count = 0;

    always #5 clk = ~clk;

    ram_pair_read_sequencer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .LEN_W      (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base0      (base0),
        .base1      (base1),
        .len        (len),
        .read_addr0 (read_addr0),
        .read_addr1 (read_addr1),
        .ram_dout0  (ram_dout0),
        .ram_dout1  (ram_dout1),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DW'(i);
        end
    end

    // 1-cycle registered read, two ports on one array
    always @(posedge clk) begin
        ram_dout0 <= mem[read_addr0];
        ram_dout1 <= mem[read_addr1];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Model: a command becomes a list of expected pairs; phase 0 idle, 1 active, 2 done cycle
    typedef struct packed {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          last;
    } pair_t;

    pair_t exp_q[$];
    int    phase      = 0;
    bit    exp_reset  = 1'b0;
    bit    prev_stall = 1'b0;

    always @(negedge clk) begin
        pair_t p;
        bit    hs;
        if (exp_reset) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_read_addr0", read_addr0, 0);
            chk("rst_read_addr1", read_addr1, 0);
            chk("rst_out_data0", out_data0, 0);
            chk("rst_out_data1", out_data1, 0);
        end else begin
            chk("busy", busy, phase == 1);
            chk("done", done, phase == 2);
            if (prev_stall) begin
                chk("valid_held_while_stalled", out_valid, 1);
            end
            if (exp_q.size() == 0) begin
                chk("no_pair_pending_valid", out_valid, 0);
            end else if (out_valid) begin
                chk("pair_data0", out_data0, exp_q[0].d0);
                chk("pair_data1", out_data1, exp_q[0].d1);
                chk("pair_last", out_last, exp_q[0].last);
            end
        end

        if (rst) begin
            exp_q.delete();
            phase      = 0;
            exp_reset  = 1'b1;
            prev_stall = 1'b0;
        end else begin
            exp_reset  = 1'b0;
            hs         = out_valid && out_ready;
            prev_stall = out_valid && !out_ready;
            case (phase)
                0: begin
                    if (start) begin
                        if (len == '0) begin
                            phase = 2;
                        end else begin
                            phase = 1;
                            for (int k = 0; k < int'(len); k++) begin
                                p.d0   = DW'((int'(base0) + k) % DEPTH);
                                p.d1   = DW'((int'(base1) + k) % DEPTH);
                                p.last = (k == int'(len) - 1);
                                exp_q.push_back(p);
                            end
                        end
                    end
                end
                1: begin
                    if (hs && exp_q.size() > 0) begin
                        p = exp_q.pop_front();
                        hs_count++;
                        if (p.last) begin
                            phase = 2;
                        end
                    end
                end
                default: phase = 0;
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [AW-1:0] b0, input logic [AW-1:0] b1, input logic [LEN_W-1:0] l);
        base0 = b0;
        base1 = b1;
        len   = l;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Leaves the DUT back in IDLE so the next start is sampled
    task automatic wait_done(input int max_cyc, input bit toggle);
        bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            out_ready = toggle ? pat[i % 6] : 1'b1;
            tick;
            if (done) begin
                seen = 1'b1;
            end
        end
        out_ready = 1'b1;
        chk("done_within_budget", seen, 1);
        tick;
    endtask

    initial begin
        int h0;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        base0     = '0;
        base1     = '0;
        len       = '0;
        repeat (3) tick;
        rst = 1'b0;
        tick;

        // Full-throughput command with literal timing
        start_cmd(8'd0, 8'd16, 9'd4);
        chk("t1_busy_after_start", busy, 1);
        chk("t1_valid_e0", out_valid, 0);
        tick;
        chk("t1_valid_e1", out_valid, 0);
        tick;
        chk("t1_valid_e2", out_valid, 1);
        chk("t1_p0_d0", out_data0, 0);
        chk("t1_p0_d1", out_data1, 16);
        tick;
        chk("t1_p1_d0", out_data0, 1);
        chk("t1_p1_d1", out_data1, 17);
        tick;
        chk("t1_p2_d1", out_data1, 18);
        chk("t1_p2_last", out_last, 0);
        tick;
        chk("t1_p3_d0", out_data0, 3);
        chk("t1_p3_last", out_last, 1);
        tick;
        chk("t1_done", done, 1);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_valid_at_done", out_valid, 0);
        tick;
        chk("t1_done_one_cycle", done, 0);

        // Backpressure pattern
        h0 = hs_count;
        start_cmd(8'd0, 8'd16, 9'd4);
        wait_done(80, 1'b1);
        chk("t2_pair_count", hs_count - h0, 4);

        // Address wrap at DEPTH-1
        start_cmd(8'd254, 8'd255, 9'd3);
        tick;
        tick;
        chk("t3_p0_d0", out_data0, 254);
        chk("t3_p0_d1", out_data1, 255);
        tick;
        chk("t3_p1_d0", out_data0, 255);
        chk("t3_p1_d1", out_data1, 0);
        tick;
        chk("t3_p2_d0", out_data0, 0);
        chk("t3_p2_d1", out_data1, 1);
        chk("t3_p2_last", out_last, 1);
        wait_done(10, 1'b0);

        // Zero-length command
        start_cmd(8'd5, 8'd6, 9'd0);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_valid", out_valid, 0);
        tick;
        chk("t4_done_cleared", done, 0);
        chk("t4_busy_idle", busy, 0);

        // start mid-command ignored, then a fresh command accepted
        h0 = hs_count;
        start_cmd(8'd0, 8'd16, 9'd4);
        tick;
        base0 = 8'd100;
        base1 = 8'd200;
        len   = 9'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(40, 1'b0);
        chk("t5_original_pairs", hs_count - h0, 4);
        h0 = hs_count;
        start_cmd(8'd8, 8'd9, 9'd2);
        wait_done(40, 1'b0);
        chk("t5_new_cmd_pairs", hs_count - h0, 2);

        // Reset right after the 2nd pair transfers
        start_cmd(8'd0, 8'd16, 9'd4);
        repeat (4) tick;
        rst = 1'b1;
        tick;
        chk("t6_valid_after_rst", out_valid, 0);
        chk("t6_busy_after_rst", busy, 0);
        chk("t6_addr0_after_rst", read_addr0, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("t6_valid_stays_low", out_valid, 0);
            chk("t6_no_done", done, 0);
        end
        h0 = hs_count;
        start_cmd(8'd3, 8'd4, 9'd2);
        wait_done(30, 1'b0);
        chk("t6_restart_pairs", hs_count - h0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/ram_pair_read_sequencer.md
Name: ram_pair_read_sequencer

Overview:
- Downstream consumer of the 1-write/2-read block RAM. Drives both read addresses and streams the resulting operand pairs to the MAC array over a valid/ready interface.
- On a start command it walks two independent address streams, base0+k and base1+k, for k = 0..len-1.
- It absorbs the RAM's fixed 1-cycle registered read latency with a 2-entry skid FIFO, so downstream backpressure never drops or duplicates a pair.
- Full throughput is 1 pair/cycle.

Parameters:
- DATA_WIDTH, 1024, width of each RAM read port (dout0/dout1).
- DEPTH, 256, RAM depth. ADDR_W = $clog2(DEPTH).
- LEN_W, 9, width of the len command field. Must hold DEPTH.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe. Sampled only in IDLE.
- base0  in  ADDR_W  first address of stream 0.
- base1  in  ADDR_W  first address of stream 1.
- len  in  LEN_W  number of pairs to read.
- read_addr0  out  ADDR_W  RAM read port 0 address (registered).
- read_addr1  out  ADDR_W  RAM read port 1 address (registered).
- ram_dout0  in  DATA_WIDTH  RAM port 0 data. Valid 1 cycle after the address.
- ram_dout1  in  DATA_WIDTH  RAM port 1 data.
- out_data0  out  DATA_WIDTH  operand 0 to MAC.
- out_data1  out  DATA_WIDTH  operand 1 to MAC.
- out_valid  out  1  pair available.
- out_ready  in  1  MAC accepts the pair.
- out_last  out  1  qualifies the final pair of the command.
- busy  out  1  command in progress.
- done  out  1  single-cycle pulse after the last handshake.

Behaviour:
- Reset:
  - FSM goes to IDLE; FIFO is emptied; in-flight flag is cleared.
  - read_addr0/1=0, out_valid=0, out_last=0, busy=0, done=0, out_data0/1=0.
  - Reset asserted mid-command aborts it: no done pulse, no further outputs, subsequent RAM data discarded.
- Handshake:
  - A pair transfers on a cycle where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data0/1 and out_last hold stable.
  - out_valid never deasserts without a transfer.
- FSM states:
  - IDLE:
    - start=1 with len>0: latch len, load read_addr0=base0 and read_addr1=base1, set issued=0, go to RUN, busy=1 from the next cycle.
    - start=1 with len=0: go to DONE, no pairs produced.
  - RUN: an issue cycle occurs when issued<len and occ<2, where occ = fifo_count + inflight − (pop this cycle).
    - On an issue: the current address pair is consumed by the RAM, inflight is set for the next cycle, issued increments, and read_addr0/1 each increment by 1 modulo DEPTH (DEPTH−1 wraps to 0).
    - On a non-issue cycle the addresses hold.
    - When issued==len, go to DRAIN.
  - DRAIN: wait until inflight=0, the FIFO is empty and the last pair has transferred, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, return to IDLE. Also entered directly from DRAIN on the cycle the last pair transfers; done is asserted the following cycle.
- start while busy (RUN/DRAIN/DONE) is ignored.
- Data path:
  - The cycle after an issue, {ram_dout0, ram_dout1} is pushed into the FIFO together with a last flag (issued index == len−1).
  - The FIFO head drives out_data0/1/out_last. out_valid = FIFO non-empty.
  - Push and pop in the same cycle are both honoured.
  - Overflow is impossible by the occ rule. Push-to-full is an assertion failure for the verifier.
- Latency: start sampled at edge E0, addresses valid after E0, RAM registers at E1, FIFO pushes at E2, so out_valid is first high after E2 (3-cycle command-to-data latency with out_ready=1).
- Throughput: 1 pair/cycle with out_ready held high. After a stall, issue resumes the same cycle the pop frees a slot.
- Counters: issued is LEN_W bits. len ≤ DEPTH; larger values wrap the addresses but still deliver len pairs.

Test Plan:
- base0=0, base1=16, len=4, out_ready=1; RAM preloaded mem[i]=i → pairs (0,16),(1,17),(2,18),(3,19) on 4 consecutive cycles starting 3 cycles after start; out_last on the 4th; done 1 cycle after; busy low after done.
- Same command, out_ready toggling 1,0,0,1,0,1… → exactly 4 pairs, in order, no duplicates. Data stable while stalled. FIFO never exceeds 2. Address issue stalls while occ=2.
- base0=254, base1=255, len=3, DEPTH=256 → pairs (254,255),(255,0),(0,1).
- len=0 with start → no out_valid; done pulse within 2 cycles; busy never high for more than 1 cycle.
- start pulsed again mid-RUN with different bases → ignored; original 4 pairs delivered; a new start after done is accepted.
- rst asserted in the cycle after the 2nd pair transfers → next cycle all outputs are at reset values, no done pulse, out_valid stays 0 until a new start.
